bound_flasher_param: RTL and testbench
======================================

Name: bound_flasher_param

Overview:
Parametrised successor to the 16-lamp bound flasher. It drives a WIDTH-bit thermometer LED bar through a six-phase fill/drain sequence with parameter-set bounds. A step prescaler sets the animation rate, and an optional continuous-loop mode repeats the sequence. Flick kick-back is supported in both drain phases, and the block reports its phase, busy and done status. It sits directly between the board button/debounce logic and the LED pins.

Parameters:
- WIDTH, 16, number of LEDs (>=8).
- LO1, 5, lamp count at which drain phase 1 ends (1 <= LO1 < HI2).
- HI2, 11, lamp count at which fill phase 2 ends (HI2 <= WIDTH).
- HI3, 6, lamp count at which fill phase 3 ends (1 <= HI3 <= WIDTH).
- KB_A, 6, upper kick-back lamp count.
- KB_B, 1, lower kick-back lamp count (1 <= KB_B < KB_A < WIDTH).
- STEP_DIV, 1, clock cycles per animation step (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flick  in  1  start / kick-back request, level-sampled, already synchronised.
- loop_en  in  1  1 = restart UP1 instead of returning to IDLE after DN3.
- led_output  out  WIDTH  thermometer pattern; bit i lit iff i < n.
- phase  out  3  current phase code.
- busy  out  1  high whenever phase != IDLE.
- done  out  1  one-cycle pulse when DN3 completes.

Behaviour:
- Internal lamp count n, width $clog2(WIDTH+1). led_output = (1<<n)-1, registered. All outputs are registered.
- Reset is sampled at the clk edge when rst=1 and has the highest priority. On reset: n=0, led_output=0, phase=IDLE, prescaler=0, done=0, busy=0. Reset mid-sequence takes effect at the next edge.
- Phase codes: IDLE=0, UP1=1, DN1=2, UP2=3, DN2=4, UP3=5, DN3=6. Code 7 is illegal and goes to IDLE with n=0 on the next edge.
- Prescaler: tick=1 when the count reaches STEP_DIV-1, then the count wraps to 0. With STEP_DIV=1, tick=1 every cycle. The prescaler is held at 0 in IDLE.
- IDLE: flick=1 on any edge gives phase=UP1 and n=1 at that edge, and the prescaler restarts.
- All other updates occur only on tick edges.
- Fill phases (UP*): if n < target, n=n+1. If n == target, move to the next phase and apply its first step (n=n-1) on the same tick. The peak value is therefore displayed for exactly one step period.
- Drain phases (DN*): if n > floor, n=n-1. If n == floor, move to the next phase and apply its first step (n=n+1, or the IDLE handling) on the same tick.
- Targets and floors:
  - UP1 -> WIDTH, then DN1.
  - DN1 -> LO1, then UP2.
  - UP2 -> HI2, then DN2.
  - DN2 -> 0, then UP3.
  - UP3 -> HI3, then DN3.
  - DN3 -> 0, then IDLE, or UP1 with n=1 if loop_en=1.
- DN3 completion: done=1 for one cycle. When loop_en=0, n stays 0.
- Kick-back: on a tick in DN1 or DN2 with flick=1 and n==KB_A or n==KB_B, the block goes to the preceding fill phase (DN1->UP1, DN2->UP2) and sets n=n+1. Kick-back takes priority over floor handling. KB_B is unreachable in DN1 with the defaults; that is legal.
- flick is ignored in UP*, DN3 and on non-tick edges.
- loop_en is sampled only on the DN3 completion tick.

Decomposition:
- Package bound_flasher_pkg holds:
  - the phase_t enum, 3-bit;
  - localparam phase codes;
  - a function thermo(n, WIDTH) returning the LED pattern.
- Sub-module step_prescaler (parameter STEP_DIV; ports clk, rst, clr, tick). It holds the step-rate counter; clr is driven by IDLE.
- Phase FSM, n counter and output registers live in the top module.

Test Plan:
1. Reset and idle: rst=1 for 3 cycles, then flick=0 for 10 cycles -> led_output=0, phase=0, busy=0, done=0 throughout.
2. Full sequence, defaults, STEP_DIV=1, one-cycle flick -> n follows 1..16, 15..5, 6..11, 10..0, 1..6, 5..0 over edges 1-56. Edge 57 gives IDLE with done=1 for one cycle; peak led_output=16'hFFFF.
3. Kick-back DN1: flick held while DN1 passes n=6 -> the next tick gives phase=UP1, n=7 (led_output=16'h007F), then the block refills to 16'hFFFF.
4. Kick-back DN2 low point: flick=1 only on the tick where n=1 in DN2 -> phase=UP2, n=2 (16'h0003), then the block fills to 11 (16'h07FF).
5. Prescaler and loop: STEP_DIV=4, loop_en=1 -> n changes only every 4th cycle. After DN3 reaches n=0, the next tick gives done=1, phase=UP1, n=1, and busy never drops.
6. Mid-run reset: rst=1 during UP2 at n=9 -> the next edge gives n=0, phase=IDLE, prescaler=0. A flick after rst=0 restarts cleanly at n=1.

Source files
------------

// File: rtl/bound_flasher_pkg.sv
// Shared types and helpers for the parametrised bound flasher.
// Holds phase codes and the thermometer pattern function.
package bound_flasher_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UP1  = 3'd1,
        S_DN1  = 3'd2,
        S_UP2  = 3'd3,
        S_DN2  = 3'd4,
        S_UP3  = 3'd5,
        S_DN3  = 3'd6
    } phase_t;

    localparam logic [2:0] PH_IDLE = S_IDLE;
    localparam logic [2:0] PH_UP1  = S_UP1;
    localparam logic [2:0] PH_DN1  = S_DN1;
    localparam logic [2:0] PH_UP2  = S_UP2;
    localparam logic [2:0] PH_DN2  = S_DN2;
    localparam logic [2:0] PH_UP3  = S_UP3;
    localparam logic [2:0] PH_DN3  = S_DN3;

    localparam int THERMO_MAX = 64;

    // Bit i set iff i < n (and i < width); callers size-cast the result.
    function automatic logic [THERMO_MAX-1:0] thermo(
        input int n,
        input int width
    );
        logic [THERMO_MAX-1:0] t;
        t = '0;
        for (int i = 0; i < THERMO_MAX; i++) begin
            t[i] = (i < n) && (i < width);
        end
        return t;
    endfunction

endpackage

// File: rtl/bound_flasher_param_prescaler.sv
// Step-rate prescaler: tick once every STEP_DIV clocks.
// Ports: clk, rst (sync, high), clr (hold count at 0), tick.
module step_prescaler #(
    parameter int STEP_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/bound_flasher_param.sv
// Parametrised bound flasher: six-phase thermometer fill/drain.
// Ports: clk, rst, flick, loop_en in; led_output, phase, busy, done out.
module bound_flasher_param #(
    parameter int WIDTH    = 16,
    parameter int LO1      = 5,
    parameter int HI2      = 11,
    parameter int HI3      = 6,
    parameter int KB_A     = 6,
    parameter int KB_B     = 1,
    parameter int STEP_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flick,
    input  logic             loop_en,
    output logic [WIDTH-1:0] led_output,
    output logic [2:0]       phase,
    output logic             busy,
    output logic             done
);

    import bound_flasher_pkg::*;

    localparam int NW = $clog2(WIDTH + 1);

    localparam logic [NW-1:0] N_ONE = NW'(1);
    localparam logic [NW-1:0] N_W   = NW'(WIDTH);
    localparam logic [NW-1:0] N_LO1 = NW'(LO1);
    localparam logic [NW-1:0] N_HI2 = NW'(HI2);
    localparam logic [NW-1:0] N_HI3 = NW'(HI3);
    localparam logic [NW-1:0] N_KBA = NW'(KB_A);
    localparam logic [NW-1:0] N_KBB = NW'(KB_B);

    logic [NW-1:0] n;
    logic [NW-1:0] n_nx;
    logic [2:0]    ph_nx;
    logic          done_nx;
    logic          tick;
    logic          kick;
    logic          idle;

    assign idle = (phase == PH_IDLE);

    step_prescaler #(
        .STEP_DIV(STEP_DIV)
    ) u_pre (
        .clk  (clk),
        .rst  (rst),
        .clr  (idle),
        .tick (tick)
    );

    // Kick-back request; only honoured in the drain phases DN1/DN2.
    assign kick = flick && ((n == N_KBA) || (n == N_KBB));

    always_comb begin
        n_nx    = n;
        ph_nx   = phase;
        done_nx = 1'b0;
        case (phase)
            PH_IDLE: begin
                if (flick) begin
                    ph_nx = PH_UP1;
                    n_nx  = N_ONE;
                end
            end
            PH_UP1: begin
                if (tick) begin
                    if (n < N_W) begin
                        n_nx = n + N_ONE;
                    end else begin
                        ph_nx = PH_DN1;
                        n_nx  = n - N_ONE;
                    end
                end
            end
            PH_DN1: begin
                if (tick) begin
                    if (kick) begin
                        ph_nx = PH_UP1;
                        n_nx  = n + N_ONE;
                    end else if (n > N_LO1) begin
                        n_nx = n - N_ONE;
                    end else begin
                        ph_nx = PH_UP2;
                        n_nx  = n + N_ONE;
                    end
                end
            end
            PH_UP2: begin
                if (tick) begin
                    if (n < N_HI2) begin
                        n_nx = n + N_ONE;
                    end else begin
                        ph_nx = PH_DN2;
                        n_nx  = n - N_ONE;
                    end
                end
            end
            PH_DN2: begin
                if (tick) begin
                    if (kick) begin
                        ph_nx = PH_UP2;
                        n_nx  = n + N_ONE;
                    end else if (n != '0) begin
                        n_nx = n - N_ONE;
                    end else begin
                        ph_nx = PH_UP3;
                        n_nx  = n + N_ONE;
                    end
                end
            end
            PH_UP3: begin
                if (tick) begin
                    if (n < N_HI3) begin
                        n_nx = n + N_ONE;
                    end else begin
                        ph_nx = PH_DN3;
                        n_nx  = n - N_ONE;
                    end
                end
            end
            PH_DN3: begin
                if (tick) begin
                    if (n != '0) begin
                        n_nx = n - N_ONE;
                    end else begin
                        done_nx = 1'b1;
                        if (loop_en) begin
                            ph_nx = PH_UP1;
                            n_nx  = N_ONE;
                        end else begin
                            ph_nx = PH_IDLE;
                            n_nx  = '0;
                        end
                    end
                end
            end
            default: begin
                ph_nx = PH_IDLE;
                n_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n          <= '0;
            phase      <= PH_IDLE;
            led_output <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            n          <= n_nx;
            phase      <= ph_nx;
            led_output <= WIDTH'(thermo(int'(n_nx), WIDTH));
            done       <= done_nx;
            busy       <= (ph_nx != PH_IDLE);
        end
    end

endmodule

// File: tb/tb_bound_flasher_param.sv
// Scoreboard bench for bound_flasher_param.
// Two instances: STEP_DIV=1 (loop off) and STEP_DIV=4 (loop on).
module tb_bound_flasher_param;

    localparam int IDLE = 0;
    localparam int UP1  = 1;
    localparam int DN1  = 2;
    localparam int UP2  = 3;
    localparam int DN2  = 4;
    localparam int UP3  = 5;
    localparam int DN3  = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1 = 1'b1;
    logic        flick1 = 1'b0;
    logic        loop1 = 1'b0;
    logic [15:0] led1;
    logic [2:0]  ph1;
    logic        busy1;
    logic        done1;

    logic        rst4 = 1'b1;
    logic        flick4 = 1'b0;
    logic        loop4 = 1'b1;
    logic [15:0] led4;
    logic [2:0]  ph4;
    logic        busy4;
    logic        done4;

    bound_flasher_param #(
        .STEP_DIV(1)
    ) dut1 (
        .clk        (clk),
        .rst        (rst1),
        .flick      (flick1),
        .loop_en    (loop1),
        .led_output (led1),
        .phase      (ph1),
        .busy       (busy1),
        .done       (done1)
    );

    bound_flasher_param #(
        .STEP_DIV(4)
    ) dut4 (
        .clk        (clk),
        .rst        (rst4),
        .flick      (flick4),
        .loop_en    (loop4),
        .led_output (led4),
        .phase      (ph4),
        .busy       (busy4),
        .done       (done4)
    );

    typedef struct {
        int n;
        int ph;
        bit d;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int vectors = 0;
    int miscompares = 0;
    int cur_n = 0;
    int cur_ph = 0;

    function automatic logic [15:0] pat(input int n);
        logic [31:0] t;
        t = (32'd1 << n) - 32'd1;
        return t[15:0];
    endfunction

    task automatic check(
        input string      name,
        input logic [15:0] led,
        input logic [2:0]  ph,
        input logic        busy,
        input logic        dn,
        input exp_t        e
    );
        logic [15:0] wl;
        logic [2:0]  wp;
        logic        wb;
        wl = pat(e.n);
        wp = 3'(e.ph);
        wb = (e.ph != 0);
        vectors++;
        if (led !== wl || ph !== wp || busy !== wb || dn !== e.d) begin
            miscompares++;
            $display("FAIL %s vec %0d: got led=%h phase=%0d busy=%b done=%b, want led=%h phase=%0d busy=%b done=%b",
                     name, vectors, led, ph, busy, dn, wl, wp, wb, e.d);
        end
    endtask

    // Monitor: one expected entry per checked cycle, compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("dut1", led1, ph1, busy1, done1, e);
            end
            if (q4.size() > 0) begin
                e = q4.pop_front();
                check("dut4", led4, ph4, busy4, done4, e);
            end
        end
    end

    task automatic drive1(input bit f, input bit r, input int n,
                          input int ph, input bit d);
        @(negedge clk);
        flick1 = f;
        rst1   = r;
        q1.push_back('{n, ph, d});
    endtask

    task automatic ramp1(input int a, input int b, input int ph, input bit f);
        if (a <= b) begin
            for (int v = a; v <= b; v++) drive1(f, 1'b0, v, ph, 1'b0);
        end else begin
            for (int v = a; v >= b; v--) drive1(f, 1'b0, v, ph, 1'b0);
        end
    endtask

    task automatic drive4(input bit f, input bit r, input int n,
                          input int ph, input bit d);
        @(negedge clk);
        flick4 = f;
        rst4   = r;
        q4.push_back('{n, ph, d});
    endtask

    // Three held cycles, then the step lands on the fourth edge.
    task automatic tick4(input int n, input int ph, input bit d);
        repeat (3) drive4(1'b0, 1'b0, cur_n, cur_ph, 1'b0);
        drive4(1'b0, 1'b0, n, ph, d);
        cur_n  = n;
        cur_ph = ph;
    endtask

    task automatic ramp4(input int a, input int b, input int ph);
        if (a <= b) begin
            for (int v = a; v <= b; v++) tick4(v, ph, 1'b0);
        end else begin
            for (int v = a; v >= b; v--) tick4(v, ph, 1'b0);
        end
    endtask

    initial begin
        // reset and idle
        repeat (3) drive1(1'b0, 1'b1, 0, IDLE, 1'b0);
        repeat (10) drive1(1'b0, 1'b0, 0, IDLE, 1'b0);

        // full sequence with one-cycle flick
        drive1(1'b1, 1'b0, 1, UP1, 1'b0);
        ramp1(2, 16, UP1, 1'b0);
        ramp1(15, 5, DN1, 1'b0);
        ramp1(6, 11, UP2, 1'b0);
        ramp1(10, 0, DN2, 1'b0);
        ramp1(1, 6, UP3, 1'b0);
        ramp1(5, 0, DN3, 1'b0);
        drive1(1'b0, 1'b0, 0, IDLE, 1'b1);
        repeat (3) drive1(1'b0, 1'b0, 0, IDLE, 1'b0);

        // kick-back in DN1 at KB_A, flick ignored while refilling
        drive1(1'b1, 1'b0, 1, UP1, 1'b0);
        ramp1(2, 16, UP1, 1'b0);
        ramp1(15, 7, DN1, 1'b0);
        drive1(1'b1, 1'b0, 6, DN1, 1'b0);
        drive1(1'b1, 1'b0, 7, UP1, 1'b0);
        ramp1(8, 16, UP1, 1'b1);
        ramp1(15, 5, DN1, 1'b0);
        ramp1(6, 11, UP2, 1'b0);
        // kick-back in DN2 at KB_B
        ramp1(10, 1, DN2, 1'b0);
        drive1(1'b1, 1'b0, 2, UP2, 1'b0);
        ramp1(3, 11, UP2, 1'b0);
        // kick-back in DN2 at KB_A
        ramp1(10, 7, DN2, 1'b0);
        drive1(1'b1, 1'b0, 6, DN2, 1'b0);
        drive1(1'b1, 1'b0, 7, UP2, 1'b0);
        ramp1(8, 11, UP2, 1'b0);
        ramp1(10, 0, DN2, 1'b0);
        ramp1(1, 6, UP3, 1'b0);
        // flick ignored in DN3
        ramp1(5, 0, DN3, 1'b1);
        drive1(1'b0, 1'b0, 0, IDLE, 1'b1);
        drive1(1'b0, 1'b0, 0, IDLE, 1'b0);

        // mid-run reset in UP2 at n=9, then clean restart
        drive1(1'b1, 1'b0, 1, UP1, 1'b0);
        ramp1(2, 16, UP1, 1'b0);
        ramp1(15, 5, DN1, 1'b0);
        ramp1(6, 9, UP2, 1'b0);
        drive1(1'b0, 1'b1, 0, IDLE, 1'b0);
        drive1(1'b0, 1'b0, 0, IDLE, 1'b0);
        drive1(1'b1, 1'b0, 1, UP1, 1'b0);
        drive1(1'b0, 1'b0, 2, UP1, 1'b0);
        drive1(1'b0, 1'b0, 3, UP1, 1'b0);
        drive1(1'b0, 1'b1, 0, IDLE, 1'b0);

        // prescaler 4 with loop enabled
        repeat (2) drive4(1'b0, 1'b1, 0, IDLE, 1'b0);
        drive4(1'b1, 1'b0, 1, UP1, 1'b0);
        cur_n  = 1;
        cur_ph = UP1;
        ramp4(2, 16, UP1);
        ramp4(15, 5, DN1);
        ramp4(6, 11, UP2);
        ramp4(10, 0, DN2);
        ramp4(1, 6, UP3);
        ramp4(5, 0, DN3);
        tick4(1, UP1, 1'b1);
        ramp4(2, 3, UP1);

        repeat (2) @(posedge clk);
        #2;
        if (q1.size() != 0 || q4.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: got %0d/%0d entries left, want 0/0",
                     q1.size(), q4.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
